match_frame_sched: RTL and testbench

- Frame-level scheduler sitting above the match controller.
- Rotates three left-descriptor RAM banks (write / current / previous) and two right-descriptor banks, so feature extraction of frame N+1 overlaps matching of N vs N-1.
- Latches descriptor counts, issues a one-cycle start, supervises completion with a watchdog, and counts emitted matches.
- Publishes per-frame statistics.

---
 rtl/match_frame_sched.sv | 139 +++++++++++++
 tb/tb_match_frame_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/match_frame_sched.sv
// Frame-level scheduler: rotates descriptor RAM banks, launches the matcher once per frame,
// guards it with a watchdog and publishes per-frame match statistics.
module match_frame_sched #(
    parameter int unsigned TIMEOUT_CYC = 2000000,
    parameter int unsigned NUM_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             feat_done,
    input  logic [NUM_W-1:0] feat_num_l,
    input  logic [NUM_W-1:0] feat_num_r,
    output logic [1:0]       wr_bank_l,
    output logic             wr_bank_r,
    output logic [1:0]       cur_bank_l,
    output logic [1:0]       prev_bank_l,
    output logic             cur_bank_r,
    output logic [NUM_W-1:0] des_num_rl,
    output logic [NUM_W-1:0] des_num_rp,
    output logic [NUM_W-1:0] des_num_rr,
    output logic             match_start,
    output logic             match_abort,
    input  logic             match_done,
    input  logic             match_dout_valid,
    output logic             busy,
    output logic             stat_valid,
    output logic [NUM_W-1:0] stat_match_cnt,
    output logic             stat_skipped,
    output logic             stat_timeout,
    output logic [15:0]      frame_cnt,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_WAIT_DONE,
        S_REPORT,
        S_ABORT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WD_W-1:0]  wd;
    logic [NUM_W-1:0] match_cnt;
    logic             have_prev;
    logic             accept;
    logic             skip;
    logic             wd_expired;

    assign accept     = (state == S_IDLE) && feat_done;
    assign skip       = !have_prev || (des_num_rl == '0) || (des_num_rp == '0) || (des_num_rr == '0);
    // Watchdog is zero during START, so expiry lands TIMEOUT_CYC cycles after match_start.
    assign wd_expired = (wd == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (feat_done) state_nxt = S_SETUP;
            S_SETUP:     state_nxt = skip ? S_REPORT : S_START;
            S_START:     state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (match_done)      state_nxt = S_REPORT;
                else if (wd_expired) state_nxt = S_ABORT;
            end
            S_ABORT:     state_nxt = S_REPORT;
            S_REPORT:    state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    assign match_start    = (state == S_START);
    assign match_abort    = (state == S_ABORT);
    assign stat_valid     = (state == S_REPORT);
    assign busy           = (state != S_IDLE);
    assign stat_match_cnt = match_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_l    <= 2'd0;
            cur_bank_l   <= 2'd1;
            prev_bank_l  <= 2'd2;
            wr_bank_r    <= 1'b0;
            cur_bank_r   <= 1'b1;
            des_num_rl   <= '0;
            des_num_rp   <= '0;
            des_num_rr   <= '0;
            frame_cnt    <= '0;
            drop_cnt     <= '0;
            match_cnt    <= '0;
            wd           <= '0;
            have_prev    <= 1'b0;
            stat_skipped <= 1'b0;
            stat_timeout <= 1'b0;
        end else begin
            if (accept) begin
                cur_bank_l  <= wr_bank_l;
                prev_bank_l <= cur_bank_l;
                wr_bank_l   <= prev_bank_l;
                cur_bank_r  <= wr_bank_r;
                wr_bank_r   <= ~wr_bank_r;
                des_num_rp  <= des_num_rl;
                des_num_rl  <= feat_num_l;
                des_num_rr  <= feat_num_r;
                frame_cnt   <= frame_cnt + 16'd1;
                match_cnt   <= '0;
            end
            if (feat_done && (state != S_IDLE) && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
            case (state)
                S_SETUP: begin
                    have_prev <= 1'b1;
                    wd        <= '0;
                    if (skip) stat_skipped <= 1'b1;
                end
                S_START: wd <= wd + 1'b1;
                S_WAIT_DONE: begin
                    wd <= wd + 1'b1;
                    if (match_dout_valid && (match_cnt != '1))
                        match_cnt <= match_cnt + 1'b1;
                end
                S_ABORT: stat_timeout <= 1'b1;
                S_REPORT: begin
                    stat_skipped <= 1'b0;
                    stat_timeout <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_match_frame_sched.sv
// Scoreboarded random/directed bench for match_frame_sched: bank rotation is predicted
// from the accepted-frame count, per-frame stats are queued and checked by a monitor.
module tb_match_frame_sched;

    localparam int NW = 10;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          rst;
    logic          feat_done;
    logic [NW-1:0] feat_num_l;
    logic [NW-1:0] feat_num_r;
    logic [1:0]    wr_bank_l;
    logic          wr_bank_r;
    logic [1:0]    cur_bank_l;
    logic [1:0]    prev_bank_l;
    logic          cur_bank_r;
    logic [NW-1:0] des_num_rl;
    logic [NW-1:0] des_num_rp;
    logic [NW-1:0] des_num_rr;
    logic          match_start;
    logic          match_abort;
    logic          match_done;
    logic          match_dout_valid;
    logic          busy;
    logic          stat_valid;
    logic [NW-1:0] stat_match_cnt;
    logic          stat_skipped;
    logic          stat_timeout;
    logic [15:0]   frame_cnt;
    logic [7:0]    drop_cnt;

    match_frame_sched #(.TIMEOUT_CYC(TO), .NUM_W(NW)) dut (
        .clk(clk), .rst(rst), .feat_done(feat_done),
        .feat_num_l(feat_num_l), .feat_num_r(feat_num_r),
        .wr_bank_l(wr_bank_l), .wr_bank_r(wr_bank_r),
        .cur_bank_l(cur_bank_l), .prev_bank_l(prev_bank_l), .cur_bank_r(cur_bank_r),
        .des_num_rl(des_num_rl), .des_num_rp(des_num_rp), .des_num_rr(des_num_rr),
        .match_start(match_start), .match_abort(match_abort),
        .match_done(match_done), .match_dout_valid(match_dout_valid),
        .busy(busy), .stat_valid(stat_valid), .stat_match_cnt(stat_match_cnt),
        .stat_skipped(stat_skipped), .stat_timeout(stat_timeout),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NW-1:0] cnt;
        logic          sk;
        logic          to;
    } stat_t;

    stat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_starts = 0, exp_aborts = 0, act_starts = 0, act_aborts = 0;

    // Reference model state: frames accepted, drops seen, last two left counts, last right count.
    int m_frames, m_drops, m_l_last, m_l_prev, m_r_last;
    bit m_have_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (match_start) act_starts++;
        if (match_abort) act_aborts++;
        if (stat_valid) begin
            if (exp_q.size() == 0) begin
                chk("stat_unexpected", 32'd1, 32'd0);
            end else begin
                stat_t e;
                e = exp_q.pop_front();
                chk("stat_match_cnt", stat_match_cnt, e.cnt);
                chk("stat_skipped", stat_skipped, e.sk);
                chk("stat_timeout", stat_timeout, e.to);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_frames = 0; m_drops = 0; m_l_last = 0; m_l_prev = 0; m_r_last = 0;
        m_have_prev = 0;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = m_frames % 3;
        chk({tag, "_wr_l"}, wr_bank_l, (3 - n) % 3);
        chk({tag, "_cur_l"}, cur_bank_l, (4 - n) % 3);
        chk({tag, "_prev_l"}, prev_bank_l, (5 - n) % 3);
        chk({tag, "_wr_r"}, wr_bank_r, m_frames % 2);
        chk({tag, "_cur_r"}, cur_bank_r, (m_frames + 1) % 2);
        chk({tag, "_rl"}, des_num_rl, m_l_last);
        chk({tag, "_rp"}, des_num_rp, m_l_prev);
        chk({tag, "_rr"}, des_num_rr, m_r_last);
        chk({tag, "_frame_cnt"}, frame_cnt, m_frames % 65536);
        chk({tag, "_drop_cnt"}, drop_cnt, (m_drops > 255) ? 255 : m_drops);
    endtask

    // Drive one cycle while the DUT is known to be busy; a feat_done here is a drop.
    task automatic drive_cyc(input bit fd, input bit dv, input bit dn);
        feat_done = fd; match_dout_valid = dv; match_done = dn;
        if (fd) begin
            m_drops++;
            feat_num_l = NW'($urandom_range(1, 20));
            feat_num_r = NW'($urandom_range(1, 20));
        end
        cyc();
        feat_done = 0; match_dout_valid = 0; match_done = 0;
    endtask

    task automatic accept(input int l, input int r);
        feat_num_l = NW'(l); feat_num_r = NW'(r); feat_done = 1;
        cyc();
        feat_done = 0;
        m_frames++; m_l_prev = m_l_last; m_l_last = l; m_r_last = r;
        check_model("setup");
        chk("setup_busy", busy, 1);
        chk("setup_no_start", match_start, 0);
    endtask

    task automatic frame(input int l, input int r, input bit timeout, input int done_off,
                         input int nv, input int vpct, input int dpct, input bit rep_drop,
                         input int fdk);
        bit skip, dv, fd, dn;
        int cnt;
        stat_t e;
        skip = !m_have_prev || l == 0 || r == 0 || m_l_last == 0;
        accept(l, r);
        m_have_prev = 1;
        drive_cyc($urandom_range(99) < dpct, $urandom_range(1), $urandom_range(1));
        if (skip) begin
            e.cnt = '0; e.sk = 1'b1; e.to = 1'b0;
            exp_q.push_back(e);
            chk("skip_no_start", match_start, 0);
            chk("skip_stat_valid", stat_valid, 1);
            drive_cyc(rep_drop, 0, 0);
        end else begin
            chk("start_pulse", match_start, 1);
            exp_starts++;
            drive_cyc(0, $urandom_range(1), 0);
            cnt = 0;
            for (int k = 1; k <= TO - 1; k++) begin
                dn = !timeout && (k == done_off);
                dv = (nv >= 0) ? (k <= nv) : ($urandom_range(99) < vpct);
                fd = ($urandom_range(99) < dpct) || (k == fdk);
                if (dv) cnt++;
                drive_cyc(fd, dv, dn);
                if (dn) break;
            end
            if (timeout) begin
                chk("abort_pulse", match_abort, 1);
                exp_aborts++;
                drive_cyc($urandom_range(99) < dpct, 1, 1);
            end else begin
                chk("no_abort", match_abort, 0);
            end
            e.cnt = NW'(cnt); e.sk = 1'b0; e.to = timeout;
            exp_q.push_back(e);
            chk("report_stat_valid", stat_valid, 1);
            drive_cyc(rep_drop, 0, 0);
        end
        chk("idle_busy", busy, 0);
        check_model("end");
    endtask

    task automatic check_reset_outputs(input string tag);
        check_model(tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_stat_valid"}, stat_valid, 0);
        chk({tag, "_start"}, match_start, 0);
        chk({tag, "_abort"}, match_abort, 0);
        chk({tag, "_stat_cnt"}, stat_match_cnt, 0);
        chk({tag, "_skipped"}, stat_skipped, 0);
        chk({tag, "_timeout"}, stat_timeout, 0);
    endtask

    task automatic reset_dut();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        model_reset();
        check_reset_outputs("reset");
    endtask

    initial begin
        rst = 1; feat_done = 0; match_done = 0; match_dout_valid = 0;
        feat_num_l = '0; feat_num_r = '0;
        model_reset();
        cyc();
        reset_dut();

        frame(8, 6, 0, 5, 0, 0, 0, 0, -1);   // no previous frame: skipped
        frame(5, 4, 0, 6, 3, 0, 0, 0, -1);   // three matches
        frame(7, 7, 0, 10, -1, 40, 0, 1, 2); // drops in WAIT_DONE and REPORT
        frame(3, 9, 1, 0, -1, 30, 0, 0, -1); // watchdog abort
        frame(6, 5, 0, 8, -1, 50, 0, 0, -1);
        frame(4, 0, 0, 8, -1, 50, 0, 0, -1); // zero right count: skipped
        frame(9, 3, 0, 12, -1, 50, 0, 0, -1);
        frame(2, 2, 0, TO - 1, -1, 50, 0, 0, -1); // done coincides with watchdog expiry

        // Reset in the middle of WAIT_DONE: no stat, no abort.
        accept(11, 12);
        cyc();
        chk("rst_case_start", match_start, 1);
        exp_starts++;
        cyc();
        match_dout_valid = 1;
        cyc();
        match_dout_valid = 0;
        rst = 1;
        cyc();
        rst = 0;
        model_reset();
        check_reset_outputs("midrst");
        cyc();
        chk("midrst_no_stat", stat_valid, 0);

        for (int i = 0; i < 30; i++) begin
            int l, r, d;
            bit to;
            l  = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 500);
            r  = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 500);
            to = ($urandom_range(99) < 15);
            d  = $urandom_range(1, TO - 1);
            frame(l, r, to, d, -1, $urandom_range(80), 20, $urandom_range(1), -1);
        end
        // Heavy drop pressure to drive drop_cnt into saturation.
        for (int i = 0; i < 6; i++) frame(20, 20, 1, 0, -1, 50, 100, 1, -1);
        chk("drop_saturated", drop_cnt, 255);

        cyc();
        cyc();
        chk("start_pulses", act_starts, exp_starts);
        chk("abort_pulses", act_aborts, exp_aborts);
        chk("stat_queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
